ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter: DW, 8, data width in bits.
REQ-002 Parameter: AW, 7, address width; depth is 2**AW (128 words by default).
REQ-003 Port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port: rst_n  input  1  asynchronous active-low reset.
REQ-005 Port: init_done  output  1  high once the post-reset memory clear has completed.
REQ-006 Ports: req_a, req_b  input  1  access request from requester A or B; held until granted.
REQ-007 Ports: we_a, we_b  input  1  1 = write, 0 = read; qualified by req.
REQ-008 Ports: addr_a, addr_b  input  AW  word address.
REQ-009 Ports: wdata_a, wdata_b  input  DW  write data.
REQ-010 Ports: gnt_a, gnt_b  output  1  access accepted this cycle (combinational).
REQ-011 Ports: rvalid_a, rvalid_b  output  1  registered one-cycle pulse marking valid read data.
REQ-012 Ports: rdata_a, rdata_b  output  DW  registered read data.

Function
REQ-013 The block SHALL own a single-port 2**AW x DW memory with at most one access per clock.
REQ-014 The FSM SHALL have exactly two states, INIT and ARB.
REQ-015 INIT: a clear counter SHALL write 0 to addresses 0..2**AW-1, one per cycle, in ascending order.
REQ-016 INIT SHALL then move to ARB; with defaults, exactly 128 clear writes occur and init_done rises on the cycle after the last one.
REQ-017 In INIT, gnt_a and gnt_b SHALL be 0 regardless of requests.
REQ-018 In ARB, if exactly one req is high, that requester SHALL be granted in the same cycle.
REQ-019 In ARB, if both reqs are high, the requester not granted most recently SHALL be granted; the last-granted pointer SHALL reset to B, so A wins the first contention.
REQ-020 The last-granted pointer SHALL update only on a grant.
REQ-021 gnt_a and gnt_b SHALL never be high in the same cycle.
REQ-022 A requester contending continuously SHALL wait at most one cycle.
REQ-023 Granted write (we=1): memory[addr] SHALL take wdata at the rising edge ending the grant cycle.
REQ-024 Granted read (we=0): rdata_x SHALL carry memory[addr] and rvalid_x SHALL be high for exactly the next cycle.
REQ-025 Read latency SHALL be 1 cycle from gnt to rvalid.
REQ-026 Back-to-back granted reads SHALL produce back-to-back rvalid pulses.
REQ-027 rdata_x SHALL hold its last value when rvalid_x is low.
REQ-028 A granted write followed by a read of the same address in the next grant SHALL return the new data.
REQ-029 The block SHALL not abort or replay a granted access.
REQ-030 Requests SHALL not be queued: an ungranted req is simply re-evaluated next cycle.
REQ-031 Address wrap is not applicable; every AW-bit address is valid.

Reset
REQ-032 While rst_n=0, the following SHALL hold: state=INIT, clear counter=0, init_done=0, gnt_*=0, rvalid_*=0, rdata_*=0, pointer=B.
REQ-033 Assertion of rst_n SHALL take effect immediately without a clock edge.
REQ-034 Reset during ARB or mid-INIT SHALL restart the clear from address 0.
REQ-035 A read granted in the cycle reset asserts SHALL not produce an rvalid pulse.
REQ-036 Memory contents are not reset directly; they are zeroed only by the INIT clear sequence.

Verification
REQ-037 Release reset; hold req_a=1, we_a=0, addr_a=0x7F -> init_done rises after 128 clear cycles; gnt_a=1 the same cycle; next cycle rvalid_a=1, rdata_a=0x00.
REQ-038 After init: A writes 0x5A to 0x10; next cycle A reads 0x10 -> rdata_a=0x5A with rvalid_a one cycle after its gnt.
REQ-039 req_a and req_b held high for 6 cycles -> grants alternate A,B,A,B,A,B; never both high in one cycle.
REQ-040 Only req_b toggling while pointer=B -> B is granted every cycle it requests.
REQ-041 Pulse rst_n low at clear address 0x40, then release -> init_done low; the clear restarts at 0 and lasts 128 cycles.
REQ-042 A writes 0xA5 to 0x22 in the same cycle B requests a read of 0x22 -> A is granted; B is granted next cycle and reads 0xA5.

Source files
------------

// File: rtl/ram_arbiter_if.sv
// Request/grant/read-return bundle between two requesters (A, B) and ram_arbiter.
// The master side is the requester pair; the slave side is the arbiter.
interface ram_arbiter_if #(
  parameter int DW = 8,
  parameter int AW = 7
);
  logic          req_a;
  logic          req_b;
  logic          we_a;
  logic          we_b;
  logic [AW-1:0] addr_a;
  logic [AW-1:0] addr_b;
  logic [DW-1:0] wdata_a;
  logic [DW-1:0] wdata_b;
  logic          gnt_a;
  logic          gnt_b;
  logic          rvalid_a;
  logic          rvalid_b;
  logic [DW-1:0] rdata_a;
  logic [DW-1:0] rdata_b;

  modport master (
    output req_a, req_b, we_a, we_b, addr_a, addr_b, wdata_a, wdata_b,
    input  gnt_a, gnt_b, rvalid_a, rvalid_b, rdata_a, rdata_b
  );

  modport slave (
    input  req_a, req_b, we_a, we_b, addr_a, addr_b, wdata_a, wdata_b,
    output gnt_a, gnt_b, rvalid_a, rvalid_b, rdata_a, rdata_b
  );
endinterface

// File: rtl/ram_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port RAM that is
// zero-cleared after every reset before any request is granted.
module ram_arbiter #(
  parameter int DW = 8,
  parameter int AW = 7
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          init_done,
  ram_arbiter_if.slave  bus
);

  localparam int unsigned DEPTH = 2**AW;

  typedef enum logic {ST_INIT, ST_ARB} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] clr_cnt_q, clr_cnt_d;
  logic          init_done_q, init_done_d;
  logic          last_b_q, last_b_d;
  logic          rvalid_a_q, rvalid_a_d;
  logic          rvalid_b_q, rvalid_b_d;
  logic [DW-1:0] rdata_a_q, rdata_a_d;
  logic [DW-1:0] rdata_b_q, rdata_b_d;

  logic [DW-1:0] mem [DEPTH];
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          gnt_a, gnt_b;

  // Contention goes to whoever was not granted last; last_b_q resets to B.
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (state_q == ST_ARB) begin
      if (bus.req_a && (!bus.req_b || last_b_q)) gnt_a = 1'b1;
      else if (bus.req_b)                        gnt_b = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    init_done_d = init_done_q;
    last_b_d    = last_b_q;
    rvalid_a_d  = 1'b0;
    rvalid_b_d  = 1'b0;
    rdata_a_d   = rdata_a_q;
    rdata_b_d   = rdata_b_q;
    mem_we      = 1'b0;
    mem_addr    = clr_cnt_q;
    mem_wdata   = '0;
    case (state_q)
      ST_INIT: begin
        mem_we    = 1'b1;
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == '1) begin
          state_d     = ST_ARB;
          init_done_d = 1'b1;
        end
      end
      ST_ARB: begin
        if (gnt_a) begin
          mem_addr  = bus.addr_a;
          mem_we    = bus.we_a;
          mem_wdata = bus.wdata_a;
          last_b_d  = 1'b0;
          if (!bus.we_a) begin
            rvalid_a_d = 1'b1;
            rdata_a_d  = mem[bus.addr_a];
          end
        end else if (gnt_b) begin
          mem_addr  = bus.addr_b;
          mem_we    = bus.we_b;
          mem_wdata = bus.wdata_b;
          last_b_d  = 1'b1;
          if (!bus.we_b) begin
            rvalid_b_d = 1'b1;
            rdata_b_d  = mem[bus.addr_b];
          end
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      clr_cnt_q   <= '0;
      init_done_q <= 1'b0;
      last_b_q    <= 1'b1;
      rvalid_a_q  <= 1'b0;
      rvalid_b_q  <= 1'b0;
      rdata_a_q   <= '0;
      rdata_b_q   <= '0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      init_done_q <= init_done_d;
      last_b_q    <= last_b_d;
      rvalid_a_q  <= rvalid_a_d;
      rvalid_b_q  <= rvalid_b_d;
      rdata_a_q   <= rdata_a_d;
      rdata_b_q   <= rdata_b_d;
    end
  end

  // Storage itself is never reset; only the INIT sweep zeroes it.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  assign init_done    = init_done_q;
  assign bus.gnt_a    = gnt_a;
  assign bus.gnt_b    = gnt_b;
  assign bus.rvalid_a = rvalid_a_q;
  assign bus.rvalid_b = rvalid_b_q;
  assign bus.rdata_a  = rdata_a_q;
  assign bus.rdata_b  = rdata_b_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: clear sequence, grants, read return and reset.
module tb_ram_arbiter;

  logic clk;
  logic rst_n;
  logic init_done;
  int   n_tests;
  int   n_fail;
  int   cyc;
  logic saw_gnt;

  ram_arbiter_if #(.DW(8), .AW(7)) bus ();

  ram_arbiter #(.DW(8), .AW(7)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .init_done (init_done),
    .bus       (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_a(input logic r, input logic w, input logic [6:0] ad, input logic [7:0] wd);
    bus.req_a = r; bus.we_a = w; bus.addr_a = ad; bus.wdata_a = wd;
  endtask

  task automatic set_b(input logic r, input logic w, input logic [6:0] ad, input logic [7:0] wd);
    bus.req_b = r; bus.we_b = w; bus.addr_b = ad; bus.wdata_b = wd;
  endtask

  // Counts rising edges until init_done, bounded; flags any grant seen during INIT.
  task automatic wait_init(output int n, output logic seen);
    n = 0;
    seen = 1'b0;
    while (!init_done && n < 300) begin
      @(posedge clk); #1;
      n++;
      if (!init_done && (bus.gnt_a || bus.gnt_b)) seen = 1'b1;
    end
  endtask

  initial begin
    logic [3:0] pat;
    logic       exp_a;
    n_tests = 0;
    n_fail  = 0;
    set_a(1'b1, 1'b0, 7'h7F, 8'h00);
    set_b(1'b0, 1'b0, 7'h00, 8'h00);
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("rst_init_done", init_done, 0);
    check("rst_gnt_a", bus.gnt_a, 0);
    check("rst_rvalid_a", bus.rvalid_a, 0);
    check("rst_rvalid_b", bus.rvalid_b, 0);
    check("rst_rdata_a", bus.rdata_a, 0);
    check("rst_rdata_b", bus.rdata_b, 0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold_init_done", init_done, 0);
    check("rst_hold_gnt_a", bus.gnt_a, 0);

    // First clear after reset, with A already requesting a read of 0x7F
    @(negedge clk) rst_n = 1'b1;
    wait_init(cyc, saw_gnt);
    check("init_cycles", cyc, 128);
    check("init_no_gnt", saw_gnt, 0);
    check("first_gnt_a", bus.gnt_a, 1);
    check("first_gnt_b", bus.gnt_b, 0);
    @(posedge clk); #1;
    check("first_rvalid_a", bus.rvalid_a, 1);
    check("first_rdata_a", bus.rdata_a, 8'h00);
    set_a(1'b0, 1'b0, 7'h00, 8'h00);
    @(posedge clk); #1;
    check("pulse_end_rvalid_a", bus.rvalid_a, 0);
    check("hold_rdata_a", bus.rdata_a, 8'h00);

    // Write then read back, followed by a back-to-back read
    set_a(1'b1, 1'b1, 7'h10, 8'h5A);
    #1 check("wr_gnt_a", bus.gnt_a, 1);
    @(posedge clk); #1;
    check("wr_no_rvalid", bus.rvalid_a, 0);
    set_a(1'b1, 1'b0, 7'h10, 8'h00);
    #1 check("rd_gnt_a", bus.gnt_a, 1);
    @(posedge clk); #1;
    check("rd_rvalid_a", bus.rvalid_a, 1);
    check("rd_rdata_a", bus.rdata_a, 8'h5A);
    set_a(1'b1, 1'b0, 7'h7F, 8'h00);
    @(posedge clk); #1;
    check("b2b_rvalid_a", bus.rvalid_a, 1);
    check("b2b_rdata_a", bus.rdata_a, 8'h00);
    set_a(1'b0, 1'b0, 7'h00, 8'h00);

    // B alone, toggling request: granted exactly when requesting
    pat = 4'b1101;
    for (int i = 0; i < 4; i++) begin
      set_b(pat[i], 1'b0, 7'h10, 8'h00);
      #1;
      check("solo_gnt_b", bus.gnt_b, pat[i]);
      check("solo_gnt_a", bus.gnt_a, 0);
      @(posedge clk); #1;
      check("solo_rvalid_b", bus.rvalid_b, pat[i]);
      check("solo_rdata_b", bus.rdata_b, 8'h5A);
    end

    // Both requesting continuously: A,B,A,B,A,B
    set_a(1'b1, 1'b0, 7'h10, 8'h00);
    set_b(1'b1, 1'b0, 7'h7F, 8'h00);
    for (int i = 0; i < 6; i++) begin
      exp_a = (i % 2 == 0);
      #1;
      check("alt_gnt_a", bus.gnt_a, exp_a);
      check("alt_gnt_b", bus.gnt_b, !exp_a);
      check("alt_not_both", bus.gnt_a & bus.gnt_b, 0);
      @(posedge clk); #1;
      check("alt_rvalid_a", bus.rvalid_a, exp_a);
      check("alt_rvalid_b", bus.rvalid_b, !exp_a);
      check("alt_rdata_a", bus.rdata_a, 8'h5A);
      check("alt_rdata_b", bus.rdata_b, (i == 0) ? 8'h5A : 8'h00);
    end
    set_a(1'b0, 1'b0, 7'h00, 8'h00);
    set_b(1'b0, 1'b0, 7'h00, 8'h00);

    // Write by A and read of the same word by B in the same cycle
    set_a(1'b1, 1'b1, 7'h22, 8'hA5);
    set_b(1'b1, 1'b0, 7'h22, 8'h00);
    #1;
    check("wr_rd_gnt_a", bus.gnt_a, 1);
    check("wr_rd_gnt_b", bus.gnt_b, 0);
    @(posedge clk); #1;
    set_a(1'b0, 1'b0, 7'h00, 8'h00);
    #1 check("wr_rd_next_gnt_b", bus.gnt_b, 1);
    @(posedge clk); #1;
    check("wr_rd_rvalid_b", bus.rvalid_b, 1);
    check("wr_rd_rdata_b", bus.rdata_b, 8'hA5);
    set_b(1'b0, 1'b0, 7'h00, 8'h00);

    // Reset asserted mid-cycle while a read is being granted
    set_a(1'b1, 1'b0, 7'h22, 8'h00);
    #1 check("pre_rst_gnt_a", bus.gnt_a, 1);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_gnt_a", bus.gnt_a, 0);
    check("async_rst_init_done", init_done, 0);
    @(posedge clk); #1;
    check("rst_kill_rvalid_a", bus.rvalid_a, 0);
    check("rst_rdata_b_zero", bus.rdata_b, 0);
    set_a(1'b0, 1'b0, 7'h00, 8'h00);
    @(negedge clk) rst_n = 1'b1;

    // Interrupt the clear at address 0x40, then the full clear restarts
    repeat (64) @(posedge clk);
    #1;
    check("mid_init_done", init_done, 0);
    rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    wait_init(cyc, saw_gnt);
    check("reinit_cycles", cyc, 128);
    check("reinit_no_gnt", saw_gnt, 0);
    set_a(1'b1, 1'b0, 7'h22, 8'h00);
    @(posedge clk); #1;
    check("cleared_rvalid_a", bus.rvalid_a, 1);
    check("cleared_rdata_a", bus.rdata_a, 8'h00);
    set_a(1'b1, 1'b0, 7'h10, 8'h00);
    @(posedge clk); #1;
    check("cleared_rdata_a_10", bus.rdata_a, 8'h00);
    set_a(1'b0, 1'b0, 7'h00, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
